// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks of the rv32i core.
// Contents: cache arbiter FSM state enum, arbiter grant record enum and the
// cache line byte-offset width.
package rv32i_types;

    // Number of byte-offset bits in a cache line address (32-byte lines).
    localparam int unsigned LINE_OFFSET = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_e;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates between I-cache and D-cache line requests onto one memory port.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   i_read, i_address             I-cache fill request (level, held until i_resp)
//   i_rdata, i_resp               I-cache fill data and one-cycle completion pulse
//   d_read, d_write, d_address,   D-cache fill / writeback request
//   d_wdata
//   d_rdata, d_resp               D-cache fill data and one-cycle completion pulse
//   pmem_read, pmem_write,        shared memory request (registered, held until
//   pmem_address, pmem_wdata      pmem_resp)
//   pmem_rdata, pmem_resp         memory data and completion pulse
//
// One transaction at a time: IDLE grants (round robin on conflict), SERVE_x
// holds the memory request until pmem_resp, RESP pulses the matching resp
// output for one cycle while the line buffer drives rdata.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_e            state_q;
    arb_grant_e            last_grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  pmem_read_q;
    logic                  pmem_write_q;
    logic                  i_resp_q;
    logic                  d_resp_q;

    logic d_req;
    logic pick_d;

    // D wins when it is the only requester, or on a conflict when I had the
    // previous grant.
    always_comb begin
        d_req  = d_read | d_write;
        pick_d = d_req & (~i_read | (last_grant_q == GRANT_I));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q      <= SERVE_D;
                        last_grant_q <= GRANT_D;
                        addr_q       <= d_address;
                        // A write wins over a simultaneous read.
                        if (d_write) begin
                            pmem_write_q <= 1'b1;
                            wdata_q      <= d_wdata;
                        end else begin
                            pmem_read_q  <= 1'b1;
                        end
                    end else if (i_read) begin
                        state_q      <= SERVE_I;
                        last_grant_q <= GRANT_I;
                        addr_q       <= i_address;
                        pmem_read_q  <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Requester inputs are ignored here; only memory can end the phase.
                    if (pmem_resp) begin
                        line_q       <= pmem_rdata;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        state_q      <= RESP;
                        if (state_q == SERVE_I) begin
                            i_resp_q <= 1'b1;
                        end else begin
                            d_resp_q <= 1'b1;
                        end
                    end
                end
                // No grant here, so a requester dropping after its pulse is not re-served.
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pmem_read    = pmem_read_q;
        pmem_write   = pmem_write_q;
        pmem_address = {addr_q[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
        pmem_wdata   = wdata_q;
        i_rdata      = line_q;
        d_rdata      = line_q;
        i_resp       = i_resp_q;
        d_resp       = d_resp_q;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset state, lone fill, round-robin
// conflicts, writeback, request changes during service, mid-transaction reset.
module tb_cache_arbiter;
    import rv32i_types::*;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    localparam logic [LW-1:0] L1 = {8{32'h1111_aaaa}};
    localparam logic [LW-1:0] LD = {8{32'hdddd_0001}};
    localparam logic [LW-1:0] LI = {8{32'h5555_0002}};
    localparam logic [LW-1:0] L3 = {8{32'h3333_cccc}};
    localparam logic [LW-1:0] L4 = {8{32'h4444_0404}};
    localparam logic [LW-1:0] W1 = {8{32'hbeef_0001}};
    localparam logic [LW-1:0] W2 = {8{32'hcafe_0002}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the last mem_txn call.
    bit            t_seen, t_rd, t_wr, t_stable, t_ir, t_dr, t_drop;
    int            t_high, t_waits;
    logic [AW-1:0] t_addr;
    logic [LW-1:0] t_wd, t_idata, t_ddata;

    cache_arbiter #(
        .LINE_WIDTH(LW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    always #5 clk = ~clk;

    // Memory model: wait (bounded) for a request, hold it for 'delay' more
    // cycles, pulse pmem_resp, then sample the requester side one cycle later.
    task automatic mem_txn(input int delay, input logic [LW-1:0] data);
        t_seen = 1'b0; t_waits = 0; t_ir = 1'b0; t_dr = 1'b0; t_drop = 1'b0;
        t_high = 0; t_stable = 1'b0;
        for (int i = 0; i < 20 && !t_seen; i++) begin
            @(negedge clk);
            t_waits++;
            if (pmem_read || pmem_write) t_seen = 1'b1;
        end
        if (!t_seen) return;
        t_rd = pmem_read; t_wr = pmem_write; t_addr = pmem_address; t_wd = pmem_wdata;
        t_high = 1; t_stable = 1'b1;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) t_high++;
            if (pmem_read !== t_rd || pmem_write !== t_wr || pmem_address !== t_addr ||
                pmem_wdata !== t_wd) t_stable = 1'b0;
        end
        pmem_rdata = data;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '1;
        t_ir = i_resp; t_dr = d_resp; t_idata = i_rdata; t_ddata = d_rdata;
        t_drop = !(pmem_read || pmem_write);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
        end
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0 || pmem_address !== '0 || pmem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h expected all zero",
                     i_rdata, pmem_address, pmem_wdata);
        end
        reset_n = 1'b1;
        // Stray memory response while idle must be ignored.
        pmem_resp = 1'b1; pmem_rdata = L4;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({i_resp, d_resp, pmem_read} !== 3'b0 || i_rdata !== '0) begin
            n_fail++;
            $display("FAIL idle_resp_ignored: resp/read %b rdata %h expected 000 and 0",
                     {i_resp, d_resp, pmem_read}, i_rdata);
        end
    endtask

    task automatic test_conflict();
        i_read = 1'b1; i_address = 32'h0000_0100; d_read = 1'b1; d_address = 32'h0000_0200;
        mem_txn(1, LD);
        n_checks++;
        if (!t_seen || t_addr !== 32'h0000_0200 || !t_dr || t_ir || t_ddata !== LD) begin
            n_fail++;
            $display("FAIL conflict1_d_first: seen %0d addr %h dr %0d ir %0d expected 1 200 1 0",
                     t_seen, t_addr, t_dr, t_ir);
        end
        // D re-requests at once: second conflict, I must win now.
        d_address = 32'h0000_0300;
        mem_txn(1, LI);
        n_checks++;
        if (!t_seen || t_addr !== 32'h0000_0100 || !t_ir || t_dr || t_idata !== LI) begin
            n_fail++;
            $display("FAIL conflict2_i_first: seen %0d addr %h ir %0d dr %0d expected 1 100 1 0",
                     t_seen, t_addr, t_ir, t_dr);
        end
        n_checks++;
        if (t_waits !== 2) begin
            n_fail++;
            $display("FAIL conflict_gap: waits %0d expected 2", t_waits);
        end
        i_read = 1'b0;
        mem_txn(1, L3);
        n_checks++;
        if (!t_seen || t_addr !== 32'h0000_0300 || !t_dr || t_ddata !== L3) begin
            n_fail++;
            $display("FAIL conflict2_d_second: seen %0d addr %h dr %0d expected 1 300 1",
                     t_seen, t_addr, t_dr);
        end
        d_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lone_i();
        i_read = 1'b1; i_address = 32'h0000_0044;
        mem_txn(3, L1);
        n_checks++;
        if (!t_seen || t_addr !== 32'h0000_0040 || t_rd !== 1'b1 || t_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_req: seen %0d addr %h rd %0d wr %0d expected 1 40 1 0",
                     t_seen, t_addr, t_rd, t_wr);
        end
        n_checks++;
        if (t_high !== 4 || !t_stable) begin
            n_fail++;
            $display("FAIL lone_read_len: high %0d stable %0d expected 4 1", t_high, t_stable);
        end
        n_checks++;
        if (!t_ir || t_dr || t_idata !== L1 || !t_drop) begin
            n_fail++;
            $display("FAIL lone_resp: ir %0d dr %0d drop %0d data %h expected 1 0 1 %h",
                     t_ir, t_dr, t_drop, t_idata, L1);
        end
        i_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_resp !== 1'b0 || pmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_single_pulse: i_resp %0d pmem_read %0d expected 0 0", i_resp, pmem_read);
        end
    endtask

    task automatic test_writeback();
        d_write = 1'b1; d_wdata = W1; d_address = 32'h0000_01f4;
        mem_txn(2, L4);
        n_checks++;
        if (!t_seen || t_wr !== 1'b1 || t_rd !== 1'b0 || t_addr !== 32'h0000_01e0) begin
            n_fail++;
            $display("FAIL wb_req: seen %0d wr %0d rd %0d addr %h expected 1 1 0 1e0",
                     t_seen, t_wr, t_rd, t_addr);
        end
        n_checks++;
        if (t_wd !== W1 || !t_stable) begin
            n_fail++;
            $display("FAIL wb_wdata: got %h stable %0d expected %h 1", t_wd, t_stable, W1);
        end
        n_checks++;
        if (!t_dr || t_ir || !t_drop) begin
            n_fail++;
            $display("FAIL wb_resp: dr %0d ir %0d drop %0d expected 1 0 1", t_dr, t_ir, t_drop);
        end
        d_read = 1'b1; d_wdata = W2; d_address = 32'h0000_0400;
        mem_txn(1, L4);
        n_checks++;
        if (!t_seen || t_wr !== 1'b1 || t_rd !== 1'b0 || t_wd !== W2) begin
            n_fail++;
            $display("FAIL rw_write_wins: seen %0d wr %0d rd %0d wdata %h expected 1 1 0 %h",
                     t_seen, t_wr, t_rd, t_wd, W2);
        end
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_change_during_service();
        bit seen = 1'b0;
        i_read = 1'b1; i_address = 32'h0000_0044;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        i_address = 32'h0000_0880; d_read = 1'b1; d_address = 32'h0000_0900;
        @(negedge clk);
        n_checks++;
        if (!seen || pmem_address !== 32'h0000_0040 || pmem_read !== 1'b1 || pmem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_held: seen %0d addr %h rd %0d wr %0d expected 1 40 1 0",
                     seen, pmem_address, pmem_read, pmem_write);
        end
        pmem_resp = 1'b1; pmem_rdata = L3;
        @(negedge clk);
        pmem_resp = 1'b0;
        n_checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== L3 || pmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_i_resp: ir %0d dr %0d rd %0d data %h expected 1 0 0 %h",
                     i_resp, d_resp, pmem_read, i_rdata, L3);
        end
        i_read = 1'b0;
        mem_txn(0, L4);
        n_checks++;
        if (!t_seen || t_waits !== 2 || t_addr !== 32'h0000_0900 || !t_dr || t_ddata !== L4) begin
            n_fail++;
            $display("FAIL chg_d_after_gap: seen %0d waits %0d addr %h dr %0d expected 1 2 900 1",
                     t_seen, t_waits, t_addr, t_dr);
        end
        d_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        bit any_resp = 1'b0;
        i_read = 1'b1; i_address = 32'h0000_0500;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (!seen || pmem_read !== 1'b0 || i_resp !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL mid_reset_abort: seen %0d rd %0d ir %0d state %0d expected 1 0 0 0",
                     seen, pmem_read, i_resp, dut.state_q);
        end
        // Memory answers the aborted request during reset; it must be dropped.
        pmem_resp = 1'b1; pmem_rdata = L1;
        @(negedge clk);
        pmem_resp = 1'b0;
        if (i_resp) any_resp = 1'b1;
        n_checks++;
        if (pmem_read !== 1'b0 || any_resp) begin
            n_fail++;
            $display("FAIL mid_reset_no_grant: rd %0d resp %0d expected 0 0", pmem_read, any_resp);
        end
        reset_n = 1'b1;
        mem_txn(0, L3);
        n_checks++;
        if (!t_seen || t_waits !== 1 || t_addr !== 32'h0000_0500 || !t_ir || t_idata !== L3) begin
            n_fail++;
            $display("FAIL post_reset_grant: seen %0d waits %0d addr %h ir %0d expected 1 1 500 1",
                     t_seen, t_waits, t_addr, t_ir);
        end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_lone_i();
        test_writeback();
        test_change_during_service();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
